// File: rtl/motor_pkg.sv
// ---------------------------------------------------------------------------
// motor_pkg
//   Shared definitions for the motor PWM driver:
//     - H-bridge direction codes (coast / forward / reverse / brake)
//     - per-channel state enum
//     - direction-to-state mapping and on-time computation helpers
//   No ports; imported by motor_channel and motor_pwm_driver.
// ---------------------------------------------------------------------------
package motor_pkg;

    localparam logic [1:0] DIR_COAST = 2'b00;
    localparam logic [1:0] DIR_FWD   = 2'b01;
    localparam logic [1:0] DIR_REV   = 2'b10;
    localparam logic [1:0] DIR_BRAKE = 2'b11;

    typedef enum logic [1:0] {
        ST_COAST = 2'b00,
        ST_DRIVE = 2'b01,
        ST_DEAD  = 2'b10,
        ST_BRAKE = 2'b11
    } ch_state_t;

    // Steady state a channel settles in for a given direction code.
    function automatic ch_state_t state_for_dir(input logic [1:0] dir);
        ch_state_t st;
        case (dir)
            DIR_COAST: st = ST_COAST;
            DIR_FWD:   st = ST_DRIVE;
            DIR_REV:   st = ST_DRIVE;
            DIR_BRAKE: st = ST_BRAKE;
            default:   st = ST_COAST;
        endcase
        return st;
    endfunction

    // On-time in clocks: min(duty*scale, period), product kept at 40 bits
    // so no combination of 8-bit duty and 32-bit scale can wrap.
    function automatic logic [31:0] on_time(input logic [7:0]  duty,
                                            input logic [31:0] scale,
                                            input logic [31:0] period);
        logic [39:0] prod;
        logic [31:0] on;
        prod = {32'd0, duty} * {8'd0, scale};
        if (prod > {8'd0, period}) begin
            on = period;
        end else begin
            on = prod[31:0];
        end
        return on;
    endfunction

endpackage

// File: rtl/motor_channel.sv
// ---------------------------------------------------------------------------
// motor_channel
//   One H-bridge channel: active direction/duty, COAST/DRIVE/DEAD/BRAKE FSM,
//   dead-time counter, on-time compare and registered pin outputs.
//   Ports:
//     i_clk, i_reset    clock, synchronous active-high reset
//     i_cnt             shared PWM period counter
//     i_apply           load i_dir/i_duty as the new active command
//     i_dir, i_duty     command being applied
//     i_force_coast     immediate coast with no dead-time (watchdog)
//     o_fwd, o_rev      registered H-bridge pins
// ---------------------------------------------------------------------------
module motor_channel
    import motor_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = 10000,
    parameter int unsigned DUTY_SCALE    = 39,
    parameter int unsigned DEAD_CYCLES   = 100,
    parameter int unsigned CNT_W         = 14
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic             i_apply,
    input  logic [1:0]       i_dir,
    input  logic [7:0]       i_duty,
    input  logic             i_force_coast,
    output logic             o_fwd,
    output logic             o_rev
);

    localparam int unsigned     DEAD_W    = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

    ch_state_t         r_state, w_state_next;
    logic [1:0]        r_dir, w_dir_next;
    logic [7:0]        r_duty, w_duty_next;
    logic [DEAD_W-1:0] r_dead, w_dead_next;
    logic              r_fwd, r_rev, w_fwd_next, w_rev_next;
    logic [31:0]       w_on;
    logic              w_drive;

    assign w_on    = on_time(r_duty, DUTY_SCALE, PERIOD_CYCLES);
    assign w_drive = ({{(32-CNT_W){1'b0}}, i_cnt} < w_on);

    // Next-state, dead-time countdown and pin decode.
    always_comb begin
        w_state_next = r_state;
        w_dir_next   = r_dir;
        w_duty_next  = r_duty;
        w_dead_next  = r_dead;
        w_fwd_next   = 1'b0;
        w_rev_next   = 1'b0;

        case (r_state)
            ST_COAST: begin
                w_fwd_next = 1'b0;
                w_rev_next = 1'b0;
            end
            ST_DRIVE: begin
                w_fwd_next = (r_dir == DIR_FWD) && w_drive;
                w_rev_next = (r_dir == DIR_REV) && w_drive;
            end
            ST_DEAD: begin
                w_fwd_next = 1'b0;
                w_rev_next = 1'b0;
            end
            ST_BRAKE: begin
                w_fwd_next = 1'b1;
                w_rev_next = 1'b1;
            end
            default: begin
                w_fwd_next = 1'b0;
                w_rev_next = 1'b0;
            end
        endcase

        if (i_force_coast) begin
            w_state_next = ST_COAST;
            w_dir_next   = DIR_COAST;
            w_dead_next  = {DEAD_W{1'b0}};
        end else if (i_apply) begin
            w_dir_next  = i_dir;
            w_duty_next = i_duty;
            // While already dead the window restarts toward the newest dir;
            // leaving a non-coast dir for a different one needs dead-time.
            if ((r_state == ST_DEAD) || ((i_dir != r_dir) && (r_dir != DIR_COAST))) begin
                w_state_next = ST_DEAD;
                w_dead_next  = DEAD_LAST;
            end else begin
                w_state_next = state_for_dir(i_dir);
                w_dead_next  = {DEAD_W{1'b0}};
            end
        end else if (r_state == ST_DEAD) begin
            if (r_dead == {DEAD_W{1'b0}}) begin
                w_state_next = state_for_dir(r_dir);
            end else begin
                w_dead_next = r_dead - DEAD_W'(1);
            end
        end else begin
            w_state_next = r_state;
        end
    end

    // State, active command and pin registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_COAST;
            r_dir   <= DIR_COAST;
            r_duty  <= 8'd0;
            r_dead  <= {DEAD_W{1'b0}};
            r_fwd   <= 1'b0;
            r_rev   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_dir   <= w_dir_next;
            r_duty  <= w_duty_next;
            r_dead  <= w_dead_next;
            r_fwd   <= w_fwd_next;
            r_rev   <= w_rev_next;
        end
    end

    assign o_fwd = r_fwd;
    assign o_rev = r_rev;

endmodule

// File: rtl/motor_pwm_driver.sv
// ---------------------------------------------------------------------------
// motor_pwm_driver
//   Two-channel H-bridge PWM driver. Commands {dir, duty} for motors A and B
//   are captured into shadow registers and applied only at PWM period
//   boundaries, so pulses are never truncated mid-period.
//   Optional feature macro: MOTOR_WDOG_EN -- when defined, WDOG_PERIODS
//   boundaries without an accepted command force both channels to coast.
//   Ports:
//     i_clk, i_reset                 clock, synchronous active-high reset
//     i_cmd_valid / o_cmd_ready      command handshake
//     i_cmd_dir_a/b, i_cmd_duty_a/b  command fields
//     o_mota_fwd/rev, o_motb_fwd/rev registered H-bridge pins
//     o_period_tick                  high in the cnt==0 cycle of each period
// ---------------------------------------------------------------------------
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = 10000,
    parameter int unsigned DUTY_SCALE    = 39,
    parameter int unsigned DEAD_CYCLES   = 100
`ifdef MOTOR_WDOG_EN
    ,
    parameter int unsigned WDOG_PERIODS  = 8
`endif
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [1:0] i_cmd_dir_a,
    input  logic [1:0] i_cmd_dir_b,
    input  logic [7:0] i_cmd_duty_a,
    input  logic [7:0] i_cmd_duty_b,
    output logic       o_mota_fwd,
    output logic       o_mota_rev,
    output logic       o_motb_fwd,
    output logic       o_motb_rev,
    output logic       o_period_tick
);

    localparam int unsigned      CNT_W    = $clog2(PERIOD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pending;
    logic [1:0]       r_sh_dir_a, r_sh_dir_b;
    logic [7:0]       r_sh_duty_a, r_sh_duty_b;
    logic             w_boundary, w_accept, w_apply, w_wdog_fire;

    assign w_boundary    = (r_cnt == CNT_LAST);
    assign o_cmd_ready   = !r_pending && !i_reset;
    assign w_accept      = i_cmd_valid && o_cmd_ready;
    assign w_apply       = w_boundary && r_pending && !w_wdog_fire;
    // Decoded from the registered counter and gated by reset so the tick
    // is also present in the very first period after reset.
    assign o_period_tick = (r_cnt == {CNT_W{1'b0}}) && !i_reset;

    // PWM period counter, wraps at PERIOD_CYCLES-1.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_boundary) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Shadow command registers and pending flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pending   <= 1'b0;
            r_sh_dir_a  <= DIR_COAST;
            r_sh_dir_b  <= DIR_COAST;
            r_sh_duty_a <= 8'd0;
            r_sh_duty_b <= 8'd0;
        end else if (w_wdog_fire) begin
            r_pending  <= 1'b0;
            r_sh_dir_a <= DIR_COAST;
            r_sh_dir_b <= DIR_COAST;
        end else if (w_apply) begin
            r_pending <= 1'b0;
        end else if (w_accept) begin
            r_pending   <= 1'b1;
            r_sh_dir_a  <= i_cmd_dir_a;
            r_sh_dir_b  <= i_cmd_dir_b;
            r_sh_duty_a <= i_cmd_duty_a;
            r_sh_duty_b <= i_cmd_duty_b;
        end else begin
            r_pending <= r_pending;
        end
    end

`ifdef MOTOR_WDOG_EN
    localparam int unsigned      WDOG_W    = $clog2(WDOG_PERIODS + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_PERIODS - 1);

    logic [WDOG_W-1:0] r_wdog_cnt;

    // An accept in the boundary cycle itself resets the count, so that
    // boundary is not counted and cannot fire.
    assign w_wdog_fire = w_boundary && !w_accept && (r_wdog_cnt == WDOG_LAST);

    // Boundaries seen since the last accepted command; restarts after firing.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wdog_cnt <= {WDOG_W{1'b0}};
        end else if (w_accept || w_wdog_fire) begin
            r_wdog_cnt <= {WDOG_W{1'b0}};
        end else if (w_boundary) begin
            r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
        end else begin
            r_wdog_cnt <= r_wdog_cnt;
        end
    end
`else
    assign w_wdog_fire = 1'b0;
`endif

    motor_channel #(
        .PERIOD_CYCLES (PERIOD_CYCLES),
        .DUTY_SCALE    (DUTY_SCALE),
        .DEAD_CYCLES   (DEAD_CYCLES),
        .CNT_W         (CNT_W)
    ) u_chan_a (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_cnt         (r_cnt),
        .i_apply       (w_apply),
        .i_dir         (r_sh_dir_a),
        .i_duty        (r_sh_duty_a),
        .i_force_coast (w_wdog_fire),
        .o_fwd         (o_mota_fwd),
        .o_rev         (o_mota_rev)
    );

    motor_channel #(
        .PERIOD_CYCLES (PERIOD_CYCLES),
        .DUTY_SCALE    (DUTY_SCALE),
        .DEAD_CYCLES   (DEAD_CYCLES),
        .CNT_W         (CNT_W)
    ) u_chan_b (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_cnt         (r_cnt),
        .i_apply       (w_apply),
        .i_dir         (r_sh_dir_b),
        .i_duty        (r_sh_duty_b),
        .i_force_coast (w_wdog_fire),
        .o_fwd         (o_motb_fwd),
        .o_rev         (o_motb_rev)
    );

endmodule
